// File: rtl/key_matrix_scan_if.sv
// rtl/key_matrix_scan_if.sv - keypad pins and key events exchanged with key_matrix_scan
// master = the scanner, slave = the keypad / consumer side.
interface key_matrix_scan_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = $clog2(ROWS * COLS)
);
  logic [ROWS-1:0] key_row_i;
  logic [COLS-1:0] key_col_o;
  logic            key_flag;
  logic [KW-1:0]   key_value;
  logic            key_release;
  logic            key_err;

  modport master (
    input  key_row_i,
    output key_col_o, key_flag, key_value, key_release, key_err
  );

  modport slave (
    output key_row_i,
    input  key_col_o, key_flag, key_value, key_release, key_err
  );
endinterface

// File: rtl/key_matrix_scan.sv
// rtl/key_matrix_scan.sv - ROWS x COLS debounced keypad scanner with chord rejection
// Optional auto-repeat of held keys is enabled by defining KEY_REPEAT_EN.
module key_matrix_scan #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int SETTLE_CYCLES = 4,
  parameter int RPT_DELAY     = 25_000_000,
  parameter int RPT_PERIOD    = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  key_matrix_scan_if.master kp
);
  localparam int KW   = $clog2(ROWS * COLS);
  localparam int NK   = ROWS * COLS;
  localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int CW   = $clog2(COLS);
  localparam int SW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LEAD = 2;

  if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || DEB_CYCLES < 1 ||
      SETTLE_CYCLES < 1 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_params
    $error("key_matrix_scan: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_P_FILT, S_SCAN, S_RESULT, S_WAIT_R, S_R_FILT
  } state_t;

  state_t          r_state, w_next;
  logic [ROWS-1:0] r_sync1, r_sync2;
  logic [DW-1:0]   r_deb;
  logic [CW-1:0]   r_col;
  logic [SW-1:0]   r_set;
  logic [NK-1:0]   r_hit;
  logic [KW-1:0]   r_value;
  logic            r_flag, r_err, r_release;

  logic            w_rows_any, w_deb_done, w_set_last, w_col_last, w_one_hot;
  logic [KW-1:0]   w_index;
  logic            w_flag, w_err, w_release;
  logic [COLS-1:0] w_col_drive;
  int              w_lead;

  assign w_rows_any = (r_sync2 != '1);
  assign w_deb_done = (int'(r_deb) == DEB_CYCLES - 1);
  assign w_set_last = (int'(r_set) == SETTLE_CYCLES - 1);
  assign w_col_last = (int'(r_col) == COLS - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= kp.key_row_i;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_rows_any) w_next = S_P_FILT;
      S_P_FILT: if (!w_rows_any) w_next = S_IDLE;
                else if (w_deb_done) w_next = S_SCAN;
      S_SCAN:   if (w_set_last && w_col_last) w_next = S_RESULT;
      S_RESULT: w_next = S_WAIT_R;
      S_WAIT_R: if (!w_rows_any) w_next = S_R_FILT;
      S_R_FILT: if (w_rows_any) w_next = S_WAIT_R;
                else if (w_deb_done) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !(r_state == S_P_FILT || r_state == S_R_FILT)) r_deb <= '0;
    else if (int'(r_deb) < DEB_CYCLES - 1)                    r_deb <= r_deb + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || r_state != S_SCAN) begin
      r_col <= '0;
      r_set <= '0;
    end else if (w_set_last) begin
      r_set <= '0;
      if (!w_col_last) r_col <= r_col + 1'b1;
    end else begin
      r_set <= r_set + 1'b1;
    end
  end

  // hit[k] with k = row*COLS + col; filled on the last settle cycle of each column
  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE) begin
      r_hit <= '0;
    end else if (r_state == S_SCAN && w_set_last) begin
      for (int k = 0; k < NK; k++)
        if ((k % COLS) == int'(r_col) && !r_sync2[k / COLS]) r_hit[k] <= 1'b1;
    end
  end

  always_comb begin
    w_index   = '0;
    w_one_hot = (r_hit != '0) && ((r_hit & (r_hit - 1'b1)) == '0);
    for (int k = 0; k < NK; k++)
      if (r_hit[k]) w_index = KW'(k);
  end

`ifdef KEY_REPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int HW      = $clog2(RPT_MAX + 1);

  logic [HW-1:0] r_hold;
  logic          r_rpt_phase, r_rpt_ok, w_rpt_hit;

  assign w_rpt_hit = (r_state == S_WAIT_R) && w_rows_any && r_rpt_ok &&
                     (int'(r_hold) == (r_rpt_phase ? RPT_PERIOD : RPT_DELAY) - 1);

  always_ff @(posedge clk) begin
    if (rst || r_state != S_WAIT_R || !w_rows_any) begin
      r_hold      <= '0;
      r_rpt_phase <= 1'b0;
    end else if (w_rpt_hit) begin
      r_hold      <= '0;
      r_rpt_phase <= 1'b1;
    end else if (int'(r_hold) < RPT_MAX) begin
      r_hold      <= r_hold + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                        r_rpt_ok <= 1'b0;
    else if (r_state == S_RESULT)   r_rpt_ok <= w_one_hot;
  end
`endif

  // Column drive runs LEAD cycles ahead of the hit sampling so the two-flop
  // row synchroniser delay is hidden inside each column's settle window.
  always_comb begin
    w_lead    = -1;
    w_flag    = 1'b0;
    w_err     = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_P_FILT: if (int'(r_deb) + LEAD >= DEB_CYCLES)
                  w_lead = (int'(r_deb) + LEAD - DEB_CYCLES) / SETTLE_CYCLES;
      S_SCAN:   w_lead = int'(r_col) + (int'(r_set) + LEAD) / SETTLE_CYCLES;
      S_RESULT: begin
        w_flag = w_one_hot;
        w_err  = !w_one_hot;
      end
`ifdef KEY_REPEAT_EN
      S_WAIT_R: w_flag = w_rpt_hit;
`endif
      S_R_FILT: w_release = !w_rows_any && w_deb_done;
      default:  ;
    endcase
    w_col_drive = '0;
    if (w_lead >= 0 && w_lead < COLS)
      for (int k = 0; k < COLS; k++) w_col_drive[k] = (k != w_lead);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag    <= 1'b0;
      r_err     <= 1'b0;
      r_release <= 1'b0;
      r_value   <= '0;
    end else begin
      r_flag    <= w_flag;
      r_err     <= w_err;
      r_release <= w_release;
      if (r_state == S_RESULT && w_one_hot) r_value <= w_index;
    end
  end

  assign kp.key_col_o   = w_col_drive;
  assign kp.key_flag    = r_flag;
  assign kp.key_value   = r_value;
  assign kp.key_release = r_release;
  assign kp.key_err     = r_err;
endmodule

// File: tb/tb_key_matrix_scan.sv
// tb/tb_key_matrix_scan.sv - self-checking bench for key_matrix_scan with a keypad pin model
// Define KEY_REPEAT_EN for both bench and RTL to check the auto-repeat build.
module tb_key_matrix_scan;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DEB    = 16;
  localparam int SETTLE = 2;
  localparam int RPT_D  = 40;
  localparam int RPT_P  = 10;
  // pin edge -> key_flag: two synchroniser cycles, then DEB + COLS*SETTLE + 2
  localparam int LAT    = 2 + DEB + COLS * SETTLE + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0, n_fail = 0, n_total = 0;
  bit   pressed [ROWS][COLS];
  int   fq_c[$], fq_v[$], eq_c[$], rq_c[$];

  key_matrix_scan_if #(.ROWS(ROWS), .COLS(COLS)) kp ();

  key_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .DEB_CYCLES(DEB), .SETTLE_CYCLES(SETTLE),
    .RPT_DELAY(RPT_D), .RPT_PERIOD(RPT_P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // a pressed key pulls its row low whenever its column is driven low
  always_comb begin
    kp.key_row_i = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r][c] && !kp.key_col_o[c]) kp.key_row_i[r] = 1'b0;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (kp.key_flag) begin
        fq_c.push_back(cyc);
        fq_v.push_back(int'(kp.key_value));
      end
      if (kp.key_err)     eq_c.push_back(cyc);
      if (kp.key_release) rq_c.push_back(cyc);
      if (kp.key_flag || kp.key_err || kp.key_release)
        check("pulse_exclusive",
              int'(kp.key_flag) + int'(kp.key_err) + int'(kp.key_release), 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int count_in(input int q[$], input int lo, input int hi);
    int n = 0;
    foreach (q[i]) if (q[i] >= lo && q[i] < hi) n++;
    return n;
  endfunction

  // press one key, hold, release, then compare all pulses in the window with the model
  task automatic run_press(input string tag, input int r, input int c,
                           input int hold, input int gap);
    int p, rel, hi;
    int exp_c[$], got_c[$], got_v[$];
    p = cyc;
    pressed[r][c] = 1'b1;
    tick(hold);
    rel = cyc;
    pressed[r][c] = 1'b0;
    tick(gap);
    hi = cyc;
    exp_c.push_back(p + LAT);
`ifdef KEY_REPEAT_EN
    // a repeat at cycle t needs the synced row still low in cycle t-1
    for (int t = p + LAT + RPT_D; t <= rel + 2; t += RPT_P) exp_c.push_back(t);
`endif
    foreach (fq_c[i])
      if (fq_c[i] >= p && fq_c[i] < hi) begin
        got_c.push_back(fq_c[i]);
        got_v.push_back(fq_v[i]);
      end
    check({tag, "_flag_count"}, got_c.size(), exp_c.size());
    for (int i = 0; i < exp_c.size() && i < got_c.size(); i++) begin
      check({tag, "_flag_cycle"}, got_c[i] - p, exp_c[i] - p);
      check({tag, "_flag_value"}, got_v[i], r * COLS + c);
    end
    check({tag, "_err_count"}, count_in(eq_c, p, hi), 0);
    check({tag, "_release_count"}, count_in(rq_c, rel, hi), 1);
    check({tag, "_no_early_release"}, count_in(rq_c, p, rel), 0);
  endtask

  initial begin
    int p, rel, b0, r, c, exp_value;

    // reset state
    tick(3);
    check("reset_col",     int'(kp.key_col_o), 0);
    check("reset_flag",    int'(kp.key_flag), 0);
    check("reset_value",   int'(kp.key_value), 0);
    check("reset_release", int'(kp.key_release), 0);
    check("reset_err",     int'(kp.key_err), 0);
    rst = 1'b0;
    tick(5);

    // key (2,1) held well past the first flag
    run_press("key_2_1", 2, 1, 130, 30);

    // contact bounce on key 0 never completes a debounce
    b0 = cyc;
    for (int i = 0; i < 12; i++) begin
      pressed[0][0] = (i % 2 == 0);
      tick(5);
    end
    check("bounce_flag",    count_in(fq_c, b0, cyc), 0);
    check("bounce_err",     count_in(eq_c, b0, cyc), 0);
    check("bounce_release", count_in(rq_c, b0, cyc), 0);
    run_press("key_0_settled", 0, 0, 60, 30);

    // randomized single keys
    for (int i = 0; i < 6; i++) begin
      r = int'($urandom_range(ROWS - 1, 0));
      c = int'($urandom_range(COLS - 1, 0));
      run_press("rand_key", r, c, 40 + int'($urandom_range(20, 0)), 30);
    end

    // chord: key_value keeps the previous valid press, no flag, one err
    run_press("key_1_2", 1, 2, 50, 30);
    exp_value = 1 * COLS + 2;
    p = cyc;
    pressed[0][0] = 1'b1;
    pressed[3][3] = 1'b1;
    tick(100);
    rel = cyc;
    pressed[0][0] = 1'b0;
    pressed[3][3] = 1'b0;
    tick(30);
    check("chord_err_count", count_in(eq_c, p, cyc), 1);
    check("chord_err_cycle", count_in(eq_c, p + LAT, p + LAT + 1), 1);
    check("chord_flag_count", count_in(fq_c, p, cyc), 0);
    check("chord_value_kept", int'(kp.key_value), exp_value);
    check("chord_release_count", count_in(rq_c, rel, cyc), 1);

    // reset in the middle of the column scan
    p = cyc;
    pressed[2][1] = 1'b1;
    tick(2 + DEB + 1 + 2);
    check("scan_one_col_low", $countones(~kp.key_col_o), 1);
    rst = 1'b1;
    tick(1);
    check("scan_rst_col",     int'(kp.key_col_o), 0);
    check("scan_rst_flag",    int'(kp.key_flag), 0);
    check("scan_rst_value",   int'(kp.key_value), 0);
    check("scan_rst_release", int'(kp.key_release), 0);
    check("scan_rst_err",     int'(kp.key_err), 0);
    pressed[2][1] = 1'b0;
    rst = 1'b0;
    tick(40);
    check("after_rst_flag",    count_in(fq_c, p, cyc), 0);
    check("after_rst_err",     count_in(eq_c, p, cyc), 0);
    check("after_rst_release", count_in(rq_c, p, cyc), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
